// File: rtl/count_nox_datapath.sv
// count_nox_datapath: data array, scan index and tally for the count-number-of-X engine.
// Executes init / dec_i / inc_tr and reports done / ax combinationally from registers and x_val.
module count_nox_datapath #(
    parameter int N = 8,
    parameter int W = 8,
    localparam int IW = $clog2(N + 1),
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic          dec_i,
    input  logic          inc_tr,
    input  logic [W-1:0]  x_val,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    output logic          done,
    output logic          ax,
    output logic [IW-1:0] tally,
    output logic [IW-1:0] index
);

    logic [W-1:0]  mem [N];
    logic [IW-1:0] i;
    logic [IW-1:0] tr;
    logic          wr_ok;
    logic [AW-1:0] rd_addr;

    // When N fills the address space every address is legal; otherwise reject wr_addr >= N.
    generate
        if (N == (1 << AW)) begin : g_full_range
            always_comb wr_ok = wr_en;
        end else begin : g_part_range
            always_comb wr_ok = wr_en && (wr_addr < AW'(N));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            i  <= '0;
            tr <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                mem[AW'(k)] <= '0;
            end
        end else begin
            if (init) begin
                i  <= IW'(N);
                tr <= '0;
            end else begin
                if (dec_i && (i != '0)) begin
                    i <= i - IW'(1);
                end
                if (inc_tr && (tr < IW'(N))) begin
                    tr <= tr + IW'(1);
                end
            end
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    // Entry k is examined while i == k+1; ax is masked when i == 0 so no out-of-range read matters.
    always_comb begin
        rd_addr = AW'(i - IW'(1));
        done    = (i == '0);
        ax      = !done && (mem[rd_addr] == x_val);
    end

    assign tally = tr;
    assign index = i;

endmodule

// File: tb/tb_count_nox_datapath.sv
// Self-checking bench for count_nox_datapath: directed scenarios plus randomized traffic
// against an array/integer reference model; a second N=6 instance covers out-of-range writes.
module tb_count_nox_datapath;

    localparam int N   = 8;
    localparam int W   = 8;
    localparam int IW  = $clog2(N + 1);
    localparam int AW  = $clog2(N);
    localparam int N6  = 6;
    localparam int IW6 = $clog2(N6 + 1);
    localparam int AW6 = $clog2(N6);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, init, dec_i, inc_tr, wr_en;
    logic [W-1:0]  x_val, wr_data;
    logic [AW-1:0] wr_addr;
    logic          done, ax;
    logic [IW-1:0] tally, index;

    logic           reset6, init6, dec_i6, inc_tr6, wr_en6;
    logic [W-1:0]   x_val6, wr_data6;
    logic [AW6-1:0] wr_addr6;
    logic           done6, ax6;
    logic [IW6-1:0] tally6, index6;

    count_nox_datapath #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .init(init), .dec_i(dec_i), .inc_tr(inc_tr),
        .x_val(x_val), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .ax(ax), .tally(tally), .index(index)
    );

    count_nox_datapath #(.N(N6), .W(W)) dut6 (
        .clk(clk), .reset(reset6), .init(init6), .dec_i(dec_i6), .inc_tr(inc_tr6),
        .x_val(x_val6), .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6),
        .done(done6), .ax(ax6), .tally(tally6), .index(index6)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: array contents, scan index and tally as plain integers.
    int unsigned mm [N];
    int unsigned mi;
    int unsigned mt;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_ax();
        if (mi == 0) return 0;
        return (mm[mi - 1] == int'(x_val)) ? 1 : 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".done"},  32'(done),  (mi == 0) ? 1 : 0);
        check({tag, ".ax"},    32'(ax),    model_ax());
        check({tag, ".tally"}, 32'(tally), mt);
        check({tag, ".index"}, 32'(index), mi);
    endtask

    task automatic cycle(input bit r, input bit ini, input bit d, input bit inc,
                         input bit we, input int unsigned wa, input int unsigned wd,
                         input string tag);
        reset = r; init = ini; dec_i = d; inc_tr = inc;
        wr_en = we; wr_addr = AW'(wa); wr_data = W'(wd);
        if (r) begin
            foreach (mm[k]) mm[k] = 0;
            mi = 0;
            mt = 0;
        end else begin
            if (ini) begin
                mi = N;
                mt = 0;
            end else begin
                if (d && mi > 0) mi--;
                if (inc && mt < N) mt++;
            end
            if (we && wa < N) mm[wa] = wd;
        end
        @(posedge clk);
        #1;
        reset = 0; init = 0; dec_i = 0; inc_tr = 0; wr_en = 0;
        check_all(tag);
    endtask

    task automatic cycle6(input bit ini, input bit d, input bit inc, input bit we,
                          input int unsigned wa, input int unsigned wd);
        init6 = ini; dec_i6 = d; inc_tr6 = inc;
        wr_en6 = we; wr_addr6 = AW6'(wa); wr_data6 = W'(wd);
        @(posedge clk);
        #1;
        init6 = 0; dec_i6 = 0; inc_tr6 = 0; wr_en6 = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cnt;
        int unsigned guard;
        int unsigned m6 [N6];
        int unsigned exp_t6;
        bit          exp_seq [8];
        int unsigned mix [8];

        reset = 1; init = 0; dec_i = 0; inc_tr = 0; wr_en = 0;
        wr_addr = '0; wr_data = '0; x_val = '0;
        reset6 = 1; init6 = 0; dec_i6 = 0; inc_tr6 = 0; wr_en6 = 0;
        wr_addr6 = '0; wr_data6 = '0; x_val6 = '0;
        mi = 0; mt = 0;
        foreach (mm[k]) mm[k] = 0;

        cycle(1, 0, 0, 0, 0, 0, 0, "por");
        reset6 = 0;
        check("por.done_const", 32'(done), 1);

        // Reset clears arbitrary array contents and a partially-run scan.
        for (int a = 0; a < N; a++) cycle(0, 0, 0, 0, 1, a, $urandom_range(1, 255), "rst.load");
        cycle(0, 1, 0, 1, 0, 0, 0, "rst.init");
        cycle(0, 0, 1, 0, 0, 0, 0, "rst.dec");
        cycle(1, 1, 1, 1, 1, 0, 9, "rst.pulse");
        check("rst.done", 32'(done), 1);
        check("rst.ax", 32'(ax), 0);
        check("rst.tally", 32'(tally), 0);
        check("rst.index", 32'(index), 0);
        x_val = 0;
        cycle(0, 1, 0, 0, 0, 0, 0, "rst.scan_init");
        for (int s = 0; s < N; s++) begin
            check("rst.scan_zero", 32'(ax), 1);
            cycle(0, 0, 1, 0, 0, 0, 0, "rst.scan");
        end

        // All entries match.
        for (int a = 0; a < N; a++) cycle(0, 0, 0, 0, 1, a, 5, "all.load");
        x_val = 8'h05;
        cycle(0, 1, 0, 0, 0, 0, 0, "all.init");
        cnt = 0;
        guard = 0;
        while (ax && guard < 20) begin
            cnt++;
            guard++;
            cycle(0, 0, 1, 1, 0, 0, 0, "all.step");
        end
        check("all.ax_cycles", cnt, 8);
        check("all.tally", 32'(tally), 8);
        check("all.done", 32'(done), 1);

        // Mixed array; scan goes from address 7 down to address 0.
        mix = '{3, 5, 5, 0, 5, 7, 1, 5};
        exp_seq = '{1, 0, 0, 1, 0, 1, 1, 0};
        for (int a = 0; a < N; a++) cycle(0, 0, 0, 0, 1, a, mix[a], "mix.load");
        x_val = 8'h05;
        cycle(0, 1, 0, 0, 0, 0, 0, "mix.init");
        for (int s = 0; s < N; s++) begin
            check($sformatf("mix.ax_i%0d", N - s), 32'(ax), 32'(exp_seq[s]));
            cycle(0, 0, 1, ax, 0, 0, 0, "mix.step");
        end
        check("mix.tally", 32'(tally), 4);
        check("mix.done", 32'(done), 1);

        // Priority and saturation.
        cycle(0, 1, 1, 1, 0, 0, 0, "pri.init_wins");
        check("pri.index", 32'(index), 8);
        check("pri.tally", 32'(tally), 0);
        for (int s = 0; s < N; s++) cycle(0, 0, 1, 0, 0, 0, 0, "pri.drain");
        cycle(0, 0, 1, 0, 0, 0, 0, "pri.dec_at0");
        check("sat.index0", 32'(index), 0);
        for (int s = 0; s < 10; s++) cycle(0, 0, 0, 1, 0, 0, 0, "sat.inc");
        check("sat.tallyN", 32'(tally), 8);

        // Mid-scan events.
        cycle(0, 1, 0, 0, 0, 0, 0, "mid.init");
        cycle(0, 0, 1, 0, 0, 0, 0, "mid.dec");
        check("mid.ax_before", 32'(ax), 0);
        cycle(0, 0, 0, 0, 1, 6, 5, "mid.write");
        check("mid.ax_after", 32'(ax), 1);
        cycle(0, 0, 1, 1, 0, 0, 0, "mid.a");
        cycle(0, 0, 1, 1, 0, 0, 0, "mid.b");
        cycle(0, 0, 1, 0, 0, 0, 0, "mid.c");
        cycle(0, 0, 1, 0, 0, 0, 0, "mid.d");
        check("mid.index3", 32'(index), 3);
        check("mid.tally2", 32'(tally), 2);
        cycle(0, 1, 0, 0, 0, 0, 0, "mid.reinit");
        check("reinit.index", 32'(index), 8);
        check("reinit.tally", 32'(tally), 0);
        for (int s = 0; s < 4; s++) cycle(0, 0, 1, 0, 0, 0, 0, "mid.to4");
        check("mid.index4", 32'(index), 4);
        cycle(1, 0, 0, 0, 0, 0, 0, "mid.reset");
        check("mid.reset_done", 32'(done), 1);

        // Randomized traffic, including x_val changes observed without a clock edge.
        for (int n = 0; n < 400; n++) begin
            x_val = W'($urandom_range(0, 3));
            #1;
            check("rnd.ax_comb", 32'(ax), model_ax());
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, N - 1),
                  $urandom_range(0, 3), "rnd");
        end

        // N=6: addresses 6 and 7 exist on the bus but must not write.
        check("n6.reset_done", 32'(done6), 1);
        check("n6.reset_index", 32'(index6), 0);
        for (int a = 0; a < N6; a++) begin
            m6[a] = a + 1;
            cycle6(0, 0, 0, 1, a, a + 1);
        end
        m6[2] = 8'hAA;
        cycle6(0, 0, 0, 1, 2, 8'hAA);
        cycle6(0, 0, 0, 1, 6, 8'hAA);
        cycle6(0, 0, 0, 1, 7, 8'hAA);
        x_val6 = 8'hAA;
        exp_t6 = 0;
        foreach (m6[k]) if (m6[k] == 8'hAA) exp_t6++;
        cycle6(1, 0, 0, 0, 0, 0);
        check("n6.init_index", 32'(index6), N6);
        for (int s = N6; s > 0; s--) begin
            check($sformatf("n6.ax_i%0d", s), 32'(ax6), (m6[s - 1] == 8'hAA) ? 1 : 0);
            cycle6(0, 1, ax6, 0, 0, 0);
        end
        check("n6.tally", 32'(tally6), exp_t6);
        check("n6.done", 32'(done6), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
